// File: rtl/fb_stream_loader.sv
// Packs an R,G,B byte stream into 24-bit pixels and writes whole frames into the
// back bank of a double-buffered frame memory, swapping banks on a vsync fall.
module fb_stream_loader #(
  parameter int H_PIX  = 192,
  parameter int V_PIX  = 108,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  input  logic              s_sof,
  output logic              s_ready,
  input  logic              vga_vs,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              disp_bank,
  output logic              frame_ready,
  output logic [7:0]        err_count
);

  localparam int                N_PIX     = H_PIX * V_PIX;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

  state_t            state, state_n;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              vs_d;
  logic              xfer, vs_fall;
  logic              take_r, take_g, take_b, abort, swap;
  logic [7:0]        r_byte, g_byte;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign xfer        = s_valid && s_ready;
  assign vs_fall     = vs_d && !vga_vs;
  assign frame_ready = (state == WAIT_SWAP);
  assign wr_bank     = ~disp_bank;

  always_comb begin
    state_n    = state;
    byte_idx_n = byte_idx;
    addr_n     = addr;
    take_r     = 1'b0;
    take_g     = 1'b0;
    take_b     = 1'b0;
    abort      = 1'b0;
    swap       = 1'b0;
    case (state)
      IDLE: begin
        if (xfer && s_sof) begin
          take_r     = 1'b1;
          byte_idx_n = 2'd1;
          addr_n     = '0;
          state_n    = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (s_sof) begin
            // SOF always restarts at pixel 0; only an error if mid-frame
            take_r     = 1'b1;
            byte_idx_n = 2'd1;
            addr_n     = '0;
            abort      = (byte_idx != 2'd0) || (addr != '0);
          end else begin
            case (byte_idx)
              2'd0: begin
                take_r     = 1'b1;
                byte_idx_n = 2'd1;
              end
              2'd1: begin
                take_g     = 1'b1;
                byte_idx_n = 2'd2;
              end
              default: begin
                take_b     = 1'b1;
                byte_idx_n = 2'd0;
                if (addr == LAST_ADDR) begin
                  addr_n  = '0;
                  state_n = WAIT_SWAP;
                end else begin
                  addr_n = addr + ADDR_W'(1);
                end
              end
            endcase
          end
        end
      end
      WAIT_SWAP: begin
        if (vs_fall) begin
          swap       = 1'b1;
          addr_n     = '0;
          byte_idx_n = 2'd0;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // control and registered write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      byte_idx  <= 2'd0;
      addr      <= '0;
      vs_d      <= 1'b1;
      s_ready   <= 1'b0;
      disp_bank <= 1'b0;
      err_count <= 8'd0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 24'd0;
    end else begin
      state    <= state_n;
      byte_idx <= byte_idx_n;
      addr     <= addr_n;
      vs_d     <= vga_vs;
      s_ready  <= (state_n != WAIT_SWAP);
      wr_en    <= take_b;
      if (swap)
        disp_bank <= ~disp_bank;
      if (abort)
        err_count <= sat_inc(err_count);
      if (take_b) begin
        wr_addr <= addr;
        wr_data <= {r_byte, g_byte, s_data};
      end
    end
  end

  // byte holding registers carry no control meaning, so no reset
  always_ff @(posedge clk) begin
    if (take_r) r_byte <= s_data;
    if (take_g) g_byte <= s_data;
  end

endmodule

// File: tb/tb_fb_stream_loader.sv
// Randomized bench for fb_stream_loader on a reduced 24x12 frame, checked against
// a byte/pixel-level reference model of the stream framing rules.
module tb_fb_stream_loader;

  localparam int H  = 24;
  localparam int V  = 12;
  localparam int AW = 9;
  localparam int N  = H * V;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          s_valid = 1'b0;
  logic          s_sof = 1'b0;
  logic          s_ready;
  logic          vga_vs = 1'b1;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          disp_bank;
  logic          frame_ready;
  logic [7:0]    err_count;

  fb_stream_loader #(.H_PIX(H), .V_PIX(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
    .s_ready(s_ready), .vga_vs(vga_vs), .wr_en(wr_en), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_data(wr_data), .disp_bank(disp_bank),
    .frame_ready(frame_ready), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;

  // reference model state
  int   exp_addr[$];
  int   exp_data[$];
  bit   m_in, m_wait, m_disp;
  int   m_pix, m_cnt, m_err;
  logic [7:0] m_r, m_g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_addr.delete();
    exp_data.delete();
    m_in = 0; m_wait = 0; m_disp = 0;
    m_pix = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic model_byte(input logic [7:0] d, input bit sof);
    if (sof) begin
      if (m_in && (m_cnt != 0 || m_pix != 0))
        m_err = (m_err < 255) ? m_err + 1 : 255;
      m_in = 1; m_pix = 0; m_r = d; m_cnt = 1;
    end else if (m_in) begin
      if (m_cnt == 0) begin
        m_r = d; m_cnt = 1;
      end else if (m_cnt == 1) begin
        m_g = d; m_cnt = 2;
      end else begin
        exp_addr.push_back(m_pix);
        exp_data.push_back({8'h00, m_r, m_g, d});
        m_pix++;
        m_cnt = 0;
        if (m_pix == N) begin
          m_in = 0; m_wait = 1; m_pix = 0;
        end
      end
    end
  endtask

  function automatic logic [7:0] byte_of(input int k);
    logic [31:0] pix;
    pix = k / 3;
    case (k % 3)
      0:       return pix[7:0];
      1:       return 8'h55;
      default: return 8'hAA;
    endcase
  endfunction

  // write monitor
  always @(negedge clk) begin
    if (reset_n && wr_en) begin
      wr_count++;
      if (exp_addr.size() == 0) begin
        chk("spurious_wr", 32'd1, 32'd0);
      end else begin
        chk("wr_addr", 32'(wr_addr), exp_addr.pop_front());
        chk("wr_data", 32'(wr_data), exp_data.pop_front());
      end
      chk("wr_bank", 32'(wr_bank), 32'(!m_disp));
      if (wr_addr == AW'(N - 1)) begin
        chk("last_s_ready", 32'(s_ready), 32'd0);
        chk("last_frame_ready", 32'(frame_ready), 32'd1);
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the byte transferred
  task automatic send_byte(input logic [7:0] d, input bit sof);
    bit rdy;
    int t;
    s_data = d; s_sof = sof; s_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      t++;
    end while (!rdy && t < 50);
    if (!rdy) chk("send_timeout", 32'd0, 32'd1);
    else model_byte(d, sof);
    #1;
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit sof_first, input int gap_pct);
    for (int k = lo; k <= hi; k++) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        s_valid = 1'b0;
        s_sof = 1'($urandom_range(1));
        s_data = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        s_sof = 1'b0;
      end
      send_byte(byte_of(k), (k == lo) && sof_first);
    end
  endtask

  task automatic end_frame(input string tag, input int w0);
    @(negedge clk);
    #1;
    chk({tag, "_writes"}, 32'(wr_count - w0), 32'(N));
    chk({tag, "_frame_ready"}, 32'(frame_ready), 32'(m_wait));
    chk({tag, "_s_ready"}, 32'(s_ready), 32'(!m_wait));
    chk({tag, "_pending"}, 32'(exp_addr.size()), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'(m_err));
    chk({tag, "_disp"}, 32'(disp_bank), 32'(m_disp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_swap();
    vga_vs = 1'b0;
    @(negedge clk);
    chk("pre_swap_disp", 32'(disp_bank), 32'(m_disp));
    @(posedge clk);
    #1;
    if (m_wait) begin
      m_disp = !m_disp; m_wait = 0; m_in = 0;
    end
    chk("swap_disp", 32'(disp_bank), 32'(m_disp));
    chk("swap_wr_bank", 32'(wr_bank), 32'(!m_disp));
    chk("swap_s_ready", 32'(s_ready), 32'd1);
    chk("swap_frame_ready", 32'(frame_ready), 32'd0);
    vga_vs = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_disp"}, 32'(disp_bank), 32'd0);
    chk({tag, "_wr_bank"}, 32'(wr_bank), 32'd1);
    chk({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_s_ready_low", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rel_s_ready_high", 32'(s_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bit any_rdy;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    release_reset();

    // full frame, back-to-back bytes
    w0 = wr_count;
    send_range(0, 3 * N - 1, 1'b1, 0);
    end_frame("full", w0);

    // backpressure while waiting for the swap
    w0 = wr_count;
    any_rdy = 0;
    s_valid = 1'b1; s_data = 8'($urandom);
    repeat (100) begin
      @(negedge clk);
      if (s_ready) any_rdy = 1;
    end
    s_valid = 1'b0;
    chk("bp_ready", 32'(any_rdy), 32'd0);
    chk("bp_writes", 32'(wr_count - w0), 32'd0);
    chk("bp_frame_ready", 32'(frame_ready), 32'd1);
    @(posedge clk);
    #1;
    do_swap();

    // abort at pixel 100, G byte, then a complete frame
    send_range(0, 300, 1'b1, 0);
    w0 = wr_count;
    send_byte(byte_of(0), 1'b1);
    chk("abort_err", 32'(err_count), 32'(m_err));
    chk("abort_model_err", 32'(m_err), 32'd1);
    send_byte(byte_of(1), 1'b0);
    send_byte(byte_of(2), 1'b0);
    vga_vs = 1'b0;
    send_range(3, 3 * N - 1, 1'b0, 0);
    vga_vs = 1'b1;
    end_frame("abort", w0);
    do_swap();

    // pre-SOF garbage, then a stalled frame
    w0 = wr_count;
    for (int i = 0; i < 7; i++) send_byte(8'($urandom), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("garbage_writes", 32'(wr_count - w0), 32'd0);
    send_range(0, 3 * N - 1, 1'b1, 40);
    end_frame("stall", w0);
    do_swap();

    // vsync fall during load is ignored
    w0 = wr_count;
    send_range(0, 3 * 200 - 1, 1'b1, 10);
    vga_vs = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vga_vs = 1'b1;
    chk("vs_load_disp", 32'(disp_bank), 32'(m_disp));
    chk("vs_load_frame_ready", 32'(frame_ready), 32'd0);
    send_range(3 * 200, 3 * N - 1, 1'b0, 10);
    end_frame("vsload", w0);
    do_swap();

    // one more frame so the display shows bank 1
    w0 = wr_count;
    send_range(0, 3 * N - 1, 1'b1, 20);
    end_frame("extra", w0);
    do_swap();
    chk("pre_reset_disp", 32'(disp_bank), 32'd1);

    // asynchronous reset mid-load
    send_range(0, 3 * 150 + 1, 1'b1, 20);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("midrst");
    repeat (2) @(posedge clk);
    release_reset();
    w0 = wr_count;
    send_range(0, 3 * N - 1, 1'b1, 20);
    end_frame("postrst", w0);
    do_swap();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
